// File: rtl/multi_channel_crc_serializer_if.sv
// multi_channel_crc_serializer_if: requester bus plus serial-line outputs of the CRC serializer.
interface multi_channel_crc_serializer_if #(
   parameter int CHANNELS  = 4,
   parameter int PAYLOAD_W = 32,
   parameter int CRC_W     = 8
);
   localparam int IDX_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
   logic                          enable;
   logic [CHANNELS-1:0]           ch_valid;
   logic [CHANNELS*PAYLOAD_W-1:0] ch_payload;
   logic [CHANNELS-1:0]           ch_mode;
   logic [CHANNELS-1:0]           ch_grant;
   logic [IDX_W-1:0]              cur_ch;
   logic                          busy;
   logic                          packet;
   logic                          done_tick;
   logic [CRC_W-1:0]              crc_out;
   modport master (
      output enable, ch_valid, ch_payload, ch_mode,
      input  ch_grant, cur_ch, busy, packet, done_tick, crc_out
   );
   modport slave (
      input  enable, ch_valid, ch_payload, ch_mode,
      output ch_grant, cur_ch, busy, packet, done_tick, crc_out
   );
endinterface

// File: rtl/multi_channel_crc_serializer.sv
// multi_channel_crc_serializer: round-robin arbiter feeding a start/payload/CRC/stop framed serial line.
module multi_channel_crc_serializer #(
   parameter int               CHANNELS  = 4,
   parameter int               PAYLOAD_W = 32,
   parameter int               CRC_W     = 8,
   parameter logic [CRC_W-1:0] CRC_POLY  = 8'h07,
   parameter logic [CRC_W-1:0] CRC_INIT  = 8'h00
) (
   input logic clk,
   input logic rst_n,
   multi_channel_crc_serializer_if.slave bus
);
   localparam int IDX_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
   localparam int CNT_W = $clog2((PAYLOAD_W > CRC_W ? PAYLOAD_W : CRC_W) + 1);

   typedef enum logic [2:0] {IDLE, START, DATA, CRC, STOP} state_t;

   state_t               state, state_n;
   logic [CNT_W-1:0]     cnt, cnt_n;
   logic [PAYLOAD_W-1:0] sh, sh_n;
   logic [CRC_W-1:0]     csh, csh_n;
   logic [CRC_W-1:0]     crc, crc_n, crc_upd;
   logic                 mode, mode_n;
   logic [IDX_W-1:0]     rr_ptr, rr_ptr_n, cur_ch_n, pick, idx;
   logic [CHANNELS-1:0]  grant_n;
   logic                 pick_ok, packet_n, fb;

   // First requester at or after rr_ptr, wrapping.
   always_comb begin
      pick_ok = 1'b0;
      pick    = '0;
      idx     = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         idx = IDX_W'((int'(rr_ptr) + k) % CHANNELS);
         if (!pick_ok && bus.ch_valid[idx]) begin
            pick_ok = 1'b1;
            pick    = idx;
         end
      end
   end

   // Outputs are registered from next-state values, so the grant decision is
   // taken one cycle ahead: in plain IDLE, or in STOP for back-to-back frames.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      sh_n     = sh;
      csh_n    = csh;
      crc_n    = crc;
      mode_n   = mode;
      rr_ptr_n = rr_ptr;
      cur_ch_n = bus.cur_ch;
      grant_n  = '0;
      packet_n = 1'b1;
      fb       = crc[CRC_W-1] ^ bus.packet;
      crc_upd  = {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
      if (((state == IDLE && bus.ch_grant == '0) || state == STOP) && bus.enable && pick_ok) begin
         grant_n  = CHANNELS'(1) << pick;
         cur_ch_n = pick;
         rr_ptr_n = IDX_W'((int'(pick) + 1) % CHANNELS);
      end
      case (state)
         IDLE:
            if (bus.ch_grant != '0) begin
               state_n  = START;
               packet_n = 1'b0;
               sh_n     = PAYLOAD_W'(bus.ch_payload >> (int'(bus.cur_ch) * PAYLOAD_W));
               mode_n   = bus.ch_mode[bus.cur_ch];
               crc_n    = CRC_INIT;
            end
         START: begin
            state_n  = DATA;
            packet_n = sh[PAYLOAD_W-1];
            sh_n     = sh << 1;
            cnt_n    = CNT_W'(PAYLOAD_W - 1);
         end
         DATA: begin
            crc_n = crc_upd;
            if (cnt != '0) begin
               packet_n = sh[PAYLOAD_W-1];
               sh_n     = sh << 1;
               cnt_n    = cnt - 1'b1;
            end else if (mode) begin
               state_n  = CRC;
               packet_n = crc_upd[CRC_W-1];
               csh_n    = crc_upd << 1;
               cnt_n    = CNT_W'(CRC_W - 1);
            end else
               state_n = STOP;
         end
         CRC:
            if (cnt != '0) begin
               packet_n = csh[CRC_W-1];
               csh_n    = csh << 1;
               cnt_n    = cnt - 1'b1;
            end else
               state_n = STOP;
         STOP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         sh            <= '0;
         csh           <= '0;
         crc           <= CRC_INIT;
         mode          <= 1'b0;
         rr_ptr        <= '0;
         bus.ch_grant  <= '0;
         bus.cur_ch    <= '0;
         bus.busy      <= 1'b0;
         bus.packet    <= 1'b1;
         bus.done_tick <= 1'b0;
         bus.crc_out   <= '0;
      end else begin
         state         <= state_n;
         cnt           <= cnt_n;
         sh            <= sh_n;
         csh           <= csh_n;
         crc           <= crc_n;
         mode          <= mode_n;
         rr_ptr        <= rr_ptr_n;
         bus.ch_grant  <= grant_n;
         bus.cur_ch    <= cur_ch_n;
         bus.busy      <= state_n != IDLE;
         bus.packet    <= packet_n;
         bus.done_tick <= state == STOP;
         bus.crc_out   <= state == STOP ? crc : bus.crc_out;
      end
endmodule

// File: tb/tb_multi_channel_crc_serializer.sv
// tb_multi_channel_crc_serializer: directed frames checked against a queued scoreboard and a bitwise CRC model.
module tb_multi_channel_crc_serializer;
   localparam int CH = 4, P = 32, C = 8;
   localparam int BW = $clog2(CH * P), IW = $clog2(CH);
   localparam logic [C-1:0] POLY = 8'h07, INIT = 8'h00;

   typedef struct {
      int         ch;
      logic [P-1:0] payload;
      logic       mode;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   multi_channel_crc_serializer_if #(.CHANNELS(CH), .PAYLOAD_W(P), .CRC_W(C)) bus ();
   multi_channel_crc_serializer #(
      .CHANNELS(CH), .PAYLOAD_W(P), .CRC_W(C), .CRC_POLY(POLY), .CRC_INIT(INIT)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic logic [C-1:0] crc_model(input logic [P-1:0] d);
      logic [C-1:0] c = INIT;
      for (int i = P - 1; i >= 0; i--) c = {c[C-2:0], 1'b0} ^ ((c[C-1] ^ d[i]) ? POLY : '0);
      return c;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic req(input int ch, input logic [P-1:0] d, input logic m);
      exp_t e;
      bus.ch_payload[BW'(ch * P) +: P] = d;
      bus.ch_mode[IW'(ch)]  = m;
      bus.ch_valid[IW'(ch)] = 1'b1;
      e.ch = ch;
      e.payload = d;
      e.mode = m;
      sb.push_back(e);
   endtask

   // Follows one frame from its grant cycle to its done_tick cycle; returns in the done_tick cycle.
   task automatic frame(input bit drop_valid, input bit drop_en, output int waited);
      exp_t         e;
      logic [P-1:0] got;
      logic [C-1:0] gc, ec;
      int           n = 0;
      logic         seen_done = 1'b0;
      while (bus.ch_grant == '0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      waited = n;
      chk("grant_seen", 64'(bus.ch_grant != '0), 64'(1));
      if (bus.ch_grant == '0) return;
      chk("grant_expected", 64'(sb.size() > 0), 64'(1));
      if (sb.size() == 0) return;
      e  = sb.pop_front();
      ec = crc_model(e.payload);
      chk("grant", 64'(bus.ch_grant), 64'(CH'(1) << e.ch));
      chk("cur_ch", 64'(bus.cur_ch), 64'(e.ch));
      @(negedge clk);
      if (drop_valid) begin
         bus.ch_valid   = '0;
         bus.ch_payload = {$urandom, $urandom, $urandom, $urandom};
      end
      if (drop_en) bus.enable = 1'b0;
      chk("start_bit", 64'({bus.packet, bus.busy}), 64'(2'b01));
      chk("grant_pulse", 64'(bus.ch_grant), 64'(0));
      for (int i = P - 1; i >= 0; i--) begin
         @(negedge clk);
         got[i] = bus.packet;
         seen_done |= bus.done_tick;
      end
      chk("payload", 64'(got), 64'(e.payload));
      if (e.mode) begin
         for (int i = C - 1; i >= 0; i--) begin
            @(negedge clk);
            gc[i] = bus.packet;
            seen_done |= bus.done_tick;
         end
         chk("crc_bits", 64'(gc), 64'(ec));
      end
      @(negedge clk);
      chk("stop_bit", 64'({bus.packet, bus.busy, bus.done_tick}), 64'(3'b110));
      @(negedge clk);
      chk("done", 64'({bus.done_tick, bus.busy, bus.packet, seen_done}), 64'(4'b1010));
      chk("crc_out", 64'(bus.crc_out), 64'(ec));
   endtask

   initial begin
      int   w;
      logic bad;
      bus.enable     = 1'b1;
      bus.ch_valid   = '0;
      bus.ch_payload = '0;
      bus.ch_mode    = '0;

      // Asynchronous reset between clock edges.
      repeat (2) @(posedge clk);
      #7 rst_n = 1'b0;
      #1;
      chk("rst_packet", 64'(bus.packet), 64'(1));
      chk("rst_busy", 64'(bus.busy), 64'(0));
      chk("rst_done", 64'(bus.done_tick), 64'(0));
      chk("rst_grant", 64'(bus.ch_grant), 64'(0));
      chk("rst_cur_ch", 64'(bus.cur_ch), 64'(0));
      chk("rst_crc_out", 64'(bus.crc_out), 64'(0));
      @(negedge clk) rst_n = 1'b1;
      bad = 1'b0;
      repeat (5) begin
         @(negedge clk);
         bad |= (bus.packet !== 1'b1) || (bus.busy !== 1'b0) || (bus.ch_grant !== '0);
      end
      chk("idle_after_reset", 64'(bad), 64'(0));

      // Single request with CRC.
      req(0, 32'h0000_0001, 1'b1);
      frame(1'b1, 1'b0, w);
      chk("crc_of_01", 64'(bus.crc_out), 64'(8'h07));

      // Second CRC value; ch2 stays valid so the next grant lands in the done_tick cycle.
      req(2, 32'h0000_0080, 1'b1);
      req(2, 32'h0000_0080, 1'b1);
      frame(1'b0, 1'b0, w);
      frame(1'b1, 1'b0, w);
      chk("b2b_gap", 64'(w), 64'(0));
      chk("crc_of_80", 64'(bus.crc_out), 64'(8'h89));

      // Payload only.
      req(3, 32'hA5A5_A5A5, 1'b0);
      frame(1'b1, 1'b0, w);

      // All channels valid: 0,1,2,3,0.
      for (int c = 0; c < CH; c++) req(c, $urandom, c[0]);
      req(0, bus.ch_payload[P-1:0], bus.ch_mode[0]);
      for (int i = 0; i < 5; i++) begin
         frame(i == 4, 1'b0, w);
         if (i > 0) chk("rr_b2b", 64'(w), 64'(0));
      end

      // enable dropped mid-frame: frame completes, then no grants until it returns.
      req(1, $urandom, 1'b1);
      frame(1'b0, 1'b1, w);
      bad = 1'b0;
      repeat (20) begin
         bad |= bus.ch_grant !== '0;
         @(negedge clk);
      end
      chk("no_grant_disabled", 64'(bad), 64'(0));
      req(1, bus.ch_payload[P +: P], 1'b1);
      bus.enable = 1'b1;
      frame(1'b1, 1'b0, w);

      // Reset in the DATA phase abandons the frame and rewinds the round-robin pointer.
      bus.ch_payload[2*P +: P] = 32'hDEAD_BEEF;
      bus.ch_mode[2]  = 1'b1;
      bus.ch_valid    = 4'b0100;
      w = 0;
      while (bus.ch_grant == '0 && w < 300) begin
         @(negedge clk);
         w++;
      end
      chk("abort_grant", 64'(bus.ch_grant), 64'(4'b0100));
      repeat (12) @(negedge clk);
      bus.ch_valid = 4'b1111;
      #2 rst_n = 1'b0;
      #1;
      chk("abort_outputs", 64'({bus.packet, bus.busy, bus.done_tick}), 64'(3'b100));
      bad = 1'b0;
      repeat (3) begin
         @(negedge clk);
         bad |= bus.done_tick !== 1'b0;
      end
      req(0, 32'h1234_5678, 1'b1);
      rst_n = 1'b1;
      frame(1'b1, 1'b0, w);
      chk("abort_no_done", 64'(bad), 64'(0));

      chk("sb_drained", 64'(sb.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/multi_channel_crc_serializer.md
# multi_channel_crc_serializer

Single-clock, parametrised successor of the sys_clk-domain CRC/serializer path. It accepts payload words from `CHANNELS` independent requesters and arbitrates between them round-robin. For each accepted word it computes a configurable CRC on the fly and serialises a framed packet on one line, with a per-request choice of whether the CRC is appended. It sits in domain 2, downstream of the bit synchronisers that deliver start/mode from the SPI domain. It replaces the single-channel, fixed-width CRC+serializer instance.

## Interface
- `CHANNELS`, 4, number of requesting channels (≥1)
- `PAYLOAD_W`, 32, payload bits per packet (≥1)
- `CRC_W`, 8, CRC register width (≥2)
- `CRC_POLY`, 8'h07, generator polynomial without the implicit x^CRC_W term
- `CRC_INIT`, 8'h00, CRC register value at frame start
- `CLK` input 1: system clock; all logic on the rising edge.
- `RST` input 1: asynchronous active-low reset.
- `enable` input 1: grant permission; when low, no new frame starts and an in-flight frame completes.
- `ch_valid` input CHANNELS: per-channel request level.
- `ch_payload` input CHANNELS*PAYLOAD_W: channel i occupies bits [i*PAYLOAD_W +: PAYLOAD_W].
- `ch_mode` input CHANNELS: 1 appends the CRC, 0 sends the payload only.
- `ch_grant` output CHANNELS: one-hot, one-cycle accept pulse; the payload and mode are captured in that cycle.
- `cur_ch` output max(1,$clog2(CHANNELS)): index of the last granted channel.
- `busy` output 1: high from the cycle after the grant through the stop-bit cycle.
- `packet` output 1: serial line; idles at 1.
- `done_tick` output 1: one-cycle pulse at frame end.
- `crc_out` output CRC_W: final CRC of the last frame, updated with `done_tick`.

## Operation
- States: IDLE, START, DATA, CRC, STOP.
- IDLE
  - `packet`=1.
  - If `enable` and any `ch_valid`, grant the first requesting channel at or after `rr_ptr` (wrapping), pulse `ch_grant`, capture the payload and mode, load `CRC_INIT`, and go to START.
  - `rr_ptr` becomes (granted+1) mod CHANNELS.
- START: `packet`=0 for 1 cycle, then go to DATA.
- DATA
  - `packet` = payload MSB first, for PAYLOAD_W cycles.
  - CRC update per bit: fb = crc[CRC_W-1]^bit; crc = {crc[CRC_W-2:0],1'b0} ^ (fb ? CRC_POLY : 0).
  - After the last bit, go to CRC if mode=1, otherwise go to STOP.
- CRC: `packet` = crc register MSB first (shifted out, not updated further), for CRC_W cycles; then go to STOP.
- STOP: `packet`=1 for 1 cycle, then go to IDLE.
- Leaving STOP: `done_tick`=1 and `crc_out` = computed CRC, in the first IDLE cycle. `crc_out` is updated in mode 0 too.
- Bit counter width: $clog2(max(PAYLOAD_W,CRC_W)+1). Counter wrap is not permitted mid-phase.
- Boundary conditions:
  - `ch_valid`/`ch_payload` changing after the grant is ignored.
  - A channel dropping `ch_valid` before it is granted is simply skipped.
  - Simultaneous requests: strict round-robin from `rr_ptr`, with no starvation.
  - `enable` deasserted mid-frame: the frame completes normally.
  - CHANNELS=1: the grant always goes to channel 0; `cur_ch`=0.
  - Reset at any time: state forced to IDLE immediately, and the frame is abandoned with no `done_tick`.
- Reset values: `packet`=1, `busy`=0, `done_tick`=0, `ch_grant`=0, `cur_ch`=0, `crc_out`=0, `rr_ptr`=0.

## Timing
- Grant cycle T (IDLE): `ch_grant` high.
- T+1: START bit.
- T+2…T+1+PAYLOAD_W: payload bits.
- Mode 1: CRC bits follow for CRC_W cycles.
- Then the STOP cycle, then `done_tick` in the following IDLE cycle.
- Frame length, START through STOP: 2+PAYLOAD_W+(mode?CRC_W:0) cycles, i.e. 42 for mode 1 and 34 for mode 0 at the defaults.
- The `done_tick` cycle is an IDLE cycle and may grant the next channel. This gives a back-to-back gap of exactly one idle-high cycle between the STOP bit and the next START.
- All outputs are registered; no combinational input→output path.

## Test plan
- Reset value check:
  - Assert `RST`=0 asynchronously between clock edges.
  - Required: outputs reach their reset values without a clock edge.
  - Required: after release with no requests, `packet` stays 1 and `busy` stays 0.
- Single request, CRC check:
  - Stimulus: ch0 requests payload 0x00000001 with mode=1.
  - Required: `packet` is 0, then 31×0 and a 1, then 0x07 (00000111), then 1.
  - Required: `done_tick` at T+43 and `crc_out`=0x07.
- Second CRC value and back-to-back:
  - Stimulus: ch2 requests payload 0x00000080 with mode=1.
  - Required: CRC bits are 0x89.
  - Required: with ch2 still valid, the next grant occurs in the `done_tick` cycle.
- Mode 0:
  - Stimulus: payload 0xA5A5A5A5 with mode=0.
  - Required: 34-cycle frame with no CRC bits.
  - Required: `crc_out` is still updated with the CRC of 0xA5A5A5A5 computed by the reference model.
- Round-robin and enable:
  - Stimulus: all 4 channels held valid.
  - Required: grants in order 0,1,2,3,0.
  - Stimulus: `enable` dropped mid-frame.
  - Required: the frame completes and no further grant occurs until `enable` returns.
- Mid-frame reset:
  - Stimulus: assert `RST` during the DATA phase.
  - Required: `packet` returns to 1 immediately, with no `done_tick`.
  - Required: after release, the first grant goes to ch0.
